// File: rtl/ff_arb_pkg.sv
// Shared definitions for the round-robin flip-flop arbiter: state encoding,
// round-robin pick and one-hot to index helpers.
package ff_arb_pkg;

    localparam int MAX_N = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_GRANT   = ST_GRANT,
        S_WRITE   = ST_WRITE,
        S_RELEASE = ST_RELEASE
    } state_e;

    // First set request bit scanning last+1, last+2, ... modulo n, as one-hot.
    // Vectors are sized for the largest supported requester count; bits at or
    // above n are never selected.
    function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                                 input logic [2:0]       last,
                                                 input int               n);
        logic [MAX_N-1:0] res;
        logic             found;
        int               idx;
        res   = 8'd0;
        found = 1'b0;
        for (int off = 1; off <= MAX_N; off++) begin
            if ((off <= n) && !found) begin
                idx = (int'(last) + off) % n;
                if (req[idx[2:0]]) begin
                    res[idx[2:0]] = 1'b1;
                    found         = 1'b1;
                end else begin
                    found = 1'b0;
                end
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

    // Index of the set bit in a one-hot vector (0 when the vector is empty).
    function automatic logic [2:0] oh_to_idx(input logic [MAX_N-1:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ff_reg.sv
// WIDTH-bit shared storage register with load enable. Q and its complement are
// both held in flops so Qb never glitches relative to Q.
module ff_reg #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qb_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] qb_q;

    // Load the register and its complement together; reset clears Q, sets Qb.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q  <= {WIDTH{1'b0}};
            qb_q <= {WIDTH{1'b1}};
        end else if (en_i) begin
            q_q  <= d_i;
            qb_q <= ~d_i;
        end else begin
            q_q  <= q_q;
            qb_q <= qb_q;
        end
    end

    assign q_o  = q_q;
    assign qb_o = qb_q;

endmodule

// File: rtl/ff_arbiter.sv
// Round-robin arbiter and four-phase write sequencer for one shared register.
// One requester is granted at a time; its data slice is loaded in WRITE and
// acknowledged with a single-cycle ACK pulse.
module ff_arbiter
    import ff_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N-1:0]       REQ,
    input  logic [N*WIDTH-1:0] DIN,
    output logic [N-1:0]       GNT,
    output logic [N-1:0]       ACK,
    output logic               BUSY,
    output logic [WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]   Qb
);

    state_e           state_q;
    logic [N-1:0]     gnt_q;
    logic [N-1:0]     ack_q;
    logic             busy_q;
    logic [2:0]       last_q;
    logic [2:0]       win_idx_q;

    logic [MAX_N-1:0] req_ext_s;
    logic [MAX_N-1:0] pick_d;
    logic [2:0]       pick_idx_d;
    logic             pick_any_s;
    logic             req_win_s;
    logic [WIDTH-1:0] din_sel_s;
    logic             load_en_s;

    // Round-robin choice for the next grant and the winner's live request.
    always_comb begin
        req_ext_s          = 8'd0;
        req_ext_s[N-1:0]   = REQ;
        pick_d             = rr_pick(req_ext_s, last_q, N);
        pick_idx_d         = oh_to_idx(pick_d);
        pick_any_s         = |pick_d;
        req_win_s          = req_ext_s[win_idx_q];
    end

    // Winner data mux feeding the shared register's D input.
    always_comb begin
        din_sel_s = {WIDTH{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (win_idx_q == 3'(i)) begin
                din_sel_s = DIN[i*WIDTH +: WIDTH];
            end else begin
                din_sel_s = din_sel_s;
            end
        end
    end

    assign load_en_s = (state_q == S_WRITE);

    // Sequencer: IDLE arbitrates, GRANT confirms or aborts, WRITE loads and
    // acknowledges, RELEASE waits for the winner to drop its request.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            gnt_q     <= {N{1'b0}};
            ack_q     <= {N{1'b0}};
            busy_q    <= 1'b0;
            last_q    <= 3'(N - 1);
            win_idx_q <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= {N{1'b0}};
                    if (pick_any_s) begin
                        gnt_q     <= pick_d[N-1:0];
                        win_idx_q <= pick_idx_d;
                        busy_q    <= 1'b1;
                        state_q   <= S_GRANT;
                    end else begin
                        gnt_q   <= {N{1'b0}};
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    ack_q <= {N{1'b0}};
                    if (req_win_s) begin
                        state_q <= S_WRITE;
                    end else begin
                        // Requester withdrew before the write: abort quietly,
                        // LAST stays put so the same order resumes.
                        gnt_q   <= {N{1'b0}};
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    ack_q   <= gnt_q;
                    last_q  <= win_idx_q;
                    state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    ack_q <= {N{1'b0}};
                    if (!req_win_s) begin
                        gnt_q   <= {N{1'b0}};
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_RELEASE;
                    end
                end
                default: begin
                    gnt_q   <= {N{1'b0}};
                    ack_q   <= {N{1'b0}};
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    ff_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .CLK  (CLK),
        .RST  (RST),
        .en_i (load_en_s),
        .d_i  (din_sel_s),
        .q_o  (Q),
        .qb_o (Qb)
    );

    assign GNT  = gnt_q;
    assign ACK  = ack_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_ff_arbiter.sv
// Directed self-checking bench for ff_arbiter (N=4, WIDTH=8).
`timescale 1ns/1ps
module tb_ff_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  REQ;
    logic [31:0] DIN;
    logic [3:0]  GNT;
    logic [3:0]  ACK;
    logic        BUSY;
    logic [7:0]  Q;
    logic [7:0]  Qb;

    int vecs;
    int errs;

    ff_arbiter #(.N(4), .WIDTH(8)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .REQ  (REQ),
        .DIN  (DIN),
        .GNT  (GNT),
        .ACK  (ACK),
        .BUSY (BUSY),
        .Q    (Q),
        .Qb   (Qb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Async reset pulse of 1 ns between clock edges, with immediate checks.
    task automatic pulse_reset(input string tag);
        RST = 1'b1;
        #1;
        chk({tag, "_q"},    32'(Q),    32'h00);
        chk({tag, "_qb"},   32'(Qb),   32'hFF);
        chk({tag, "_gnt"},  32'(GNT),  32'h0);
        chk({tag, "_ack"},  32'(ACK),  32'h0);
        chk({tag, "_busy"}, 32'(BUSY), 32'h0);
        RST = 1'b0;
    endtask

    // Full transaction from IDLE with REQ already set; winner drops REQ after ACK.
    task automatic do_txn(input string tag, input logic [3:0] exp_gnt, input logic [7:0] exp_q);
        logic [7:0] exp_qb;
        exp_qb = ~exp_q;
        tick();
        chk({tag, "_gnt"},      32'(GNT),  32'(exp_gnt));
        chk({tag, "_busy"},     32'(BUSY), 32'h1);
        tick();
        chk({tag, "_ack_pre"},  32'(ACK),  32'h0);
        tick();
        chk({tag, "_q"},        32'(Q),    32'(exp_q));
        chk({tag, "_qb"},       32'(Qb),   32'(exp_qb));
        chk({tag, "_ack"},      32'(ACK),  32'(exp_gnt));
        REQ = REQ & ~exp_gnt;
        tick();
        chk({tag, "_gnt_rel"},  32'(GNT),  32'h0);
        chk({tag, "_busy_rel"}, 32'(BUSY), 32'h0);
        chk({tag, "_ack_rel"},  32'(ACK),  32'h0);
    endtask

    initial begin
        logic [3:0] order [6];
        vecs = 0;
        errs = 0;
        REQ  = 4'b0000;
        DIN  = {8'h33, 8'hA5, 8'h22, 8'h11};
        RST  = 1'b1;
        #3;
        chk("rst_q",    32'(Q),    32'h00);
        chk("rst_qb",   32'(Qb),   32'hFF);
        chk("rst_gnt",  32'(GNT),  32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        #9;
        RST = 1'b0;
        tick();

        // Single request from requester 2.
        REQ = 4'b0100;
        tick();
        chk("single_gnt", 32'(GNT), 32'h4);
        chk("single_q_hold", 32'(Q), 32'h00);
        tick();
        chk("single_ack_pre", 32'(ACK), 32'h0);
        tick();
        chk("single_q",   32'(Q),   32'hA5);
        chk("single_qb",  32'(Qb),  32'h5A);
        chk("single_ack", 32'(ACK), 32'h4);
        REQ = 4'b0000;
        tick();
        chk("single_gnt_rel",  32'(GNT),  32'h0);
        chk("single_busy_rel", 32'(BUSY), 32'h0);
        chk("single_ack_one",  32'(ACK),  32'h0);

        // Reset in the middle of a WRITE.
        REQ = 4'b0001;
        tick();
        chk("mid_gnt", 32'(GNT), 32'h1);
        tick();
        chk("mid_q_before", 32'(Q), 32'hA5);
        pulse_reset("midrst");
        REQ = 4'b1111;
        do_txn("post_rst", 4'b0001, 8'h11);
        REQ = 4'b0000;

        // Fairness from reset: 0,1,3,0,1,3 with each winner re-raising.
        tick();
        pulse_reset("fair_rst");
        order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        REQ = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            logic [7:0] eq;
            case (order[k])
                4'b0001: eq = 8'h11;
                4'b0010: eq = 8'h22;
                default: eq = 8'h33;
            endcase
            do_txn($sformatf("fair%0d", k), order[k], eq);
            REQ = 4'b1011;
        end
        REQ = 4'b0000;
        tick();

        // Abort: requester 1 requests for one cycle only; LAST stays at 3.
        REQ = 4'b0010;
        tick();
        chk("abort_gnt", 32'(GNT), 32'h2);
        REQ = 4'b0000;
        tick();
        chk("abort_gnt_clr", 32'(GNT),  32'h0);
        chk("abort_busy",    32'(BUSY), 32'h0);
        chk("abort_ack",     32'(ACK),  32'h0);
        chk("abort_q",       32'(Q),    32'h33);
        tick();
        chk("abort_no_ack",  32'(ACK),  32'h0);
        chk("abort_q_hold",  32'(Q),    32'h33);
        REQ = 4'b1010;
        do_txn("after_abort", 4'b0010, 8'h22);
        do_txn("after_abort3", 4'b1000, 8'h33);
        REQ = 4'b0000;
        tick();

        // Loser pending: requester 3 rises during requester 0's WRITE.
        DIN = {8'h5C, 8'hA5, 8'h22, 8'h11};
        REQ = 4'b0001;
        tick();
        chk("pend_gnt0", 32'(GNT), 32'h1);
        tick();
        REQ = 4'b1001;
        tick();
        chk("pend_q0",    32'(Q),   32'h11);
        chk("pend_ack0",  32'(ACK), 32'h1);
        chk("pend_gnt_h", 32'(GNT), 32'h1);
        REQ = 4'b1000;
        tick();
        chk("pend_rel", 32'(GNT), 32'h0);
        tick();
        chk("pend_gnt3", 32'(GNT), 32'h8);
        tick();
        tick();
        chk("pend_q3",   32'(Q),   32'h5C);
        chk("pend_ack3", 32'(ACK), 32'h8);
        REQ = 4'b0000;
        tick();
        chk("pend_idle", 32'(BUSY), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
